// File: rtl/fp_pkg.sv
// Shared types and constants for the FPU post-add normalization stage.
package fp_pkg;

   localparam int unsigned FP_MANT_W = 24;
   localparam int unsigned FP_EXP_W  = 8;
   localparam logic [FP_EXP_W-1:0] EXP_MAX = {FP_EXP_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } norm_state_e;

   typedef struct packed {
      logic zero;
      logic ovf;
      logic unf;
   } norm_flags_t;

   localparam norm_flags_t NORM_FLAGS_CLR = '{zero: 1'b0, ovf: 1'b0, unf: 1'b0};

endpackage

// File: rtl/fp_sum_normalizer_if.sv
// Upstream (sum in) and downstream (normalized out) handshake bundle of the normalizer.
// Carries out_guard only when FP_NORM_GUARD_EN is defined.
interface fp_sum_normalizer_if #(
   parameter int unsigned MANT_W = 24,
   parameter int unsigned EXP_W  = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [MANT_W-1:0] in_sum;
   logic              in_carry;
   logic [EXP_W-1:0]  in_exp;
   logic              in_sign;

   logic              out_valid;
   logic              out_ready;
   logic [MANT_W-1:0] out_mant;
   logic [EXP_W-1:0]  out_exp;
   logic              out_sign;
   logic              out_zero;
   logic              out_ovf;
   logic              out_unf;
`ifdef FP_NORM_GUARD_EN
   logic              out_guard;
`endif

   modport slave (
      input  in_valid, in_sum, in_carry, in_exp, in_sign, out_ready,
      output in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf
`ifdef FP_NORM_GUARD_EN
      , output out_guard
`endif
   );

   modport master (
      output in_valid, in_sum, in_carry, in_exp, in_sign, out_ready,
      input  in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_ovf, out_unf
`ifdef FP_NORM_GUARD_EN
      , input out_guard
`endif
   );

endinterface

// File: rtl/fp_sum_normalizer.sv
// Post-add normalizer: right shift on carry, else serial 1-bit/cycle left shift until MSB set.
// Optional FP_NORM_GUARD_EN adds out_guard (bit shifted out on a carry right shift).
module fp_sum_normalizer
   import fp_pkg::*;
#(
   parameter int unsigned MANT_W = FP_MANT_W,
   parameter int unsigned EXP_W  = FP_EXP_W
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_sum_normalizer_if.slave   bus
);

   localparam logic [EXP_W-1:0]  EXP_TOP    = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0]  EXP_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
   localparam logic [EXP_W-1:0]  EXP_ZERO   = {EXP_W{1'b0}};
   localparam logic [EXP_W-1:0]  EXP_OVF_TH = EXP_TOP - EXP_ONE;
   localparam logic [MANT_W-1:0] MANT_ZERO  = {MANT_W{1'b0}};

   norm_state_e       state_q, state_d;
   logic [MANT_W-1:0] mant_q,  mant_d;
   logic [EXP_W-1:0]  exp_q,   exp_d;
   logic              sign_q,  sign_d;
   norm_flags_t       flags_q, flags_d;
`ifdef FP_NORM_GUARD_EN
   logic              guard_q, guard_d;
`endif

   // Next-state and datapath load/shift decisions
   always_comb begin
      state_d = state_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      sign_d  = sign_q;
      flags_d = flags_q;
`ifdef FP_NORM_GUARD_EN
      guard_d = guard_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sign_d  = bus.in_sign;
               flags_d = NORM_FLAGS_CLR;
               state_d = ST_DONE;
`ifdef FP_NORM_GUARD_EN
               guard_d = bus.in_carry & bus.in_sum[0];
`endif
               if (bus.in_carry) begin
                  // Saturate instead of wrapping when the incremented exponent reaches the top
                  if (bus.in_exp >= EXP_OVF_TH) begin
                     mant_d      = MANT_ZERO;
                     exp_d       = EXP_TOP;
                     flags_d.ovf = 1'b1;
                  end else begin
                     mant_d = {1'b1, bus.in_sum[MANT_W-1:1]};
                     exp_d  = bus.in_exp + EXP_ONE;
                  end
               end else if (bus.in_sum == MANT_ZERO) begin
                  mant_d       = MANT_ZERO;
                  exp_d        = EXP_ZERO;
                  flags_d.zero = 1'b1;
               end else if (bus.in_sum[MANT_W-1]) begin
                  mant_d = bus.in_sum;
                  exp_d  = bus.in_exp;
               end else if (bus.in_exp == EXP_ZERO) begin
                  mant_d      = bus.in_sum;
                  exp_d       = EXP_ZERO;
                  flags_d.unf = 1'b1;
               end else begin
                  mant_d  = bus.in_sum;
                  exp_d   = bus.in_exp;
                  state_d = ST_NORM;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_NORM: begin
            mant_d = {mant_q[MANT_W-2:0], 1'b0};
            exp_d  = exp_q - EXP_ONE;
            if (mant_d[MANT_W-1]) begin
               state_d = ST_DONE;
            end else if (exp_d == EXP_ZERO) begin
               flags_d.unf = 1'b1;
               state_d     = ST_DONE;
            end else begin
               state_d = ST_NORM;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mant_q  <= MANT_ZERO;
         exp_q   <= EXP_ZERO;
         sign_q  <= 1'b0;
         flags_q <= NORM_FLAGS_CLR;
`ifdef FP_NORM_GUARD_EN
         guard_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
         sign_q  <= sign_d;
         flags_q <= flags_d;
`ifdef FP_NORM_GUARD_EN
         guard_q <= guard_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_mant  = mant_q;
   assign bus.out_exp   = exp_q;
   assign bus.out_sign  = sign_q;
   assign bus.out_zero  = flags_q.zero;
   assign bus.out_ovf   = flags_q.ovf;
   assign bus.out_unf   = flags_q.unf;
`ifdef FP_NORM_GUARD_EN
   assign bus.out_guard = guard_q;
`endif

endmodule

// File: tb/tb_fp_sum_normalizer.sv
// Self-checking bench for fp_sum_normalizer (MANT_W=8, EXP_W=4): directed cases plus random
// transactions compared against a leading-zero-count reference model.
module tb_fp_sum_normalizer;

   localparam int MW = 8;
   localparam int EW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   fp_sum_normalizer_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

   fp_sum_normalizer #(.MANT_W(MW), .EXP_W(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference: normalise by counting leading zeros, limited by available exponent.
   task automatic model(input logic [MW-1:0] s, input logic c, input logic [EW-1:0] e,
                        output logic [MW-1:0] m, output logic [EW-1:0] x,
                        output logic z, output logic o, output logic u, output logic g,
                        output int k);
      int ei;
      int lz;
      ei = int'(e);
      m = '0; x = '0; z = 1'b0; o = 1'b0; u = 1'b0; g = 1'b0; k = 0;
      if (c) begin
         g = s[0];
         if (ei + 1 >= (1 << EW) - 1) begin
            o = 1'b1;
            x = EW'((1 << EW) - 1);
         end else begin
            m = MW'((int'(s) >> 1) + (1 << (MW - 1)));
            x = EW'(ei + 1);
         end
      end else if (s == 0) begin
         z = 1'b1;
      end else begin
         lz = 0;
         while (s[MW-1-lz] == 1'b0) lz++;
         k = (lz < ei) ? lz : ei;
         m = s << k;
         x = EW'(ei - k);
         u = (lz > ei);
      end
   endtask

   task automatic txn(input string nm, input logic [MW-1:0] s, input logic c,
                      input logic [EW-1:0] e, input logic sg, input int bp);
      logic [MW-1:0] em;
      logic [EW-1:0] ex;
      logic ez, eo, eu, eg;
      int k;
      int lat;
      int w;
      model(s, c, e, em, ex, ez, eo, eu, eg, k);
      @(negedge clk);
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk({nm, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.in_sum    = s;
      bus.in_carry  = c;
      bus.in_exp    = e;
      bus.in_sign   = sg;
      bus.in_valid  = 1'b1;
      bus.out_ready = (bp == 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_sum   = MW'($urandom);
      bus.in_exp   = EW'($urandom);
      lat = 0;
      while (!bus.out_valid && lat < 50) begin
         chk({nm, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
         @(posedge clk);
         #1;
         lat++;
      end
      chk({nm, ".latency"}, 32'(lat), 32'(k));
      chk({nm, ".mant"}, 32'(bus.out_mant), 32'(em));
      chk({nm, ".exp"},  32'(bus.out_exp),  32'(ex));
      chk({nm, ".sign"}, 32'(bus.out_sign), 32'(sg));
      chk({nm, ".zero"}, 32'(bus.out_zero), 32'(ez));
      chk({nm, ".ovf"},  32'(bus.out_ovf),  32'(eo));
      chk({nm, ".unf"},  32'(bus.out_unf),  32'(eu));
`ifdef FP_NORM_GUARD_EN
      chk({nm, ".guard"}, 32'(bus.out_guard), 32'(eg));
`endif
      for (int i = 0; i < bp; i++) begin
         @(posedge clk);
         #1;
         chk({nm, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
         chk({nm, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
         chk({nm, ".hold_mant"}, 32'(bus.out_mant), 32'(em));
         chk({nm, ".hold_exp"},  32'(bus.out_exp),  32'(ex));
         chk({nm, ".hold_ovf"},  32'(bus.out_ovf),  32'(eo));
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({nm, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({nm, ".ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MW-1:0] rs;
      logic          rc;
      logic [EW-1:0] re;
      bus.in_valid  = 1'b0;
      bus.in_sum    = '0;
      bus.in_carry  = 1'b0;
      bus.in_exp    = '0;
      bus.in_sign   = 1'b0;
      bus.out_ready = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst.mant", 32'(bus.out_mant), 32'd0);
      chk("rst.exp",  32'(bus.out_exp),  32'd0);
      chk("rst.flags", 32'({bus.out_zero, bus.out_ovf, bus.out_unf, bus.out_sign}), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst.in_ready", 32'(bus.in_ready), 32'd1);

      txn("t1_carry",     8'h40, 1'b1, 4'd5,  1'b0, 0);
      txn("t2_shift",     8'h05, 1'b0, 4'd9,  1'b1, 0);
      txn("t3_underflow", 8'h01, 1'b0, 4'd2,  1'b0, 0);
      txn("t4_zero",      8'h00, 1'b0, 4'd7,  1'b1, 0);
      txn("t5_ovf_bp",    8'h80, 1'b1, 4'hE,  1'b0, 3);
      txn("b_exp0",       8'h10, 1'b0, 4'd0,  1'b0, 0);
      txn("b_carry_max",  8'h33, 1'b1, 4'hD,  1'b1, 1);
      txn("b_carry_F",    8'hFF, 1'b1, 4'hF,  1'b0, 0);
      txn("b_pass",       8'h80, 1'b0, 4'd3,  1'b0, 0);
      txn("b_lz_eq_exp",  8'h10, 1'b0, 4'd3,  1'b1, 0);
      txn("b_max_shift",  8'h01, 1'b0, 4'hF,  1'b0, 2);

      // Reset during the second shift cycle of a serial normalisation
      @(negedge clk);
      bus.in_sum   = 8'h05;
      bus.in_carry = 1'b0;
      bus.in_exp   = 4'd9;
      bus.in_sign  = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t6.out_valid", 32'(bus.out_valid), 32'd0);
      chk("t6.in_ready", 32'(bus.in_ready), 32'd1);
      chk("t6.mant", 32'(bus.out_mant), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("t6.no_output", 32'(bus.out_valid), 32'd0);
      end
      txn("t6_after", 8'h40, 1'b1, 4'd5, 1'b0, 0);

      for (int n = 0; n < 60; n++) begin
         rs = MW'($urandom);
         rs = rs >> $urandom_range(0, MW);
         rc = ($urandom_range(0, 3) == 0);
         re = EW'($urandom);
         txn("rnd", rs, rc, re, 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
